uart_tx_framer: RTL and testbench

- Serialises one byte per handshake onto the UART line `Tx`: start bit (0), NBITS data bits LSB first, optional parity, STOP_BITS stop bits (1).
- Bit timing comes from the shared baud-tick pulse `tick`, which runs at 16x baud; each bit lasts TICKS_PER_BIT tick pulses.
- Sits between the host/command logic and the TX pin; it is the transmit counterpart of the UART receive path.

---
 rtl/uart_tx_framer.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_framer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: serialises one NBITS-wide word per valid/ready handshake onto Tx.
// Frame: start bit (0), NBITS data bits LSB first, optional parity, STOP_BITS stop bits (1).
// Bit timing comes from the 16x-baud tick pulse; each bit lasts TICKS_PER_BIT ticks.
// Optional feature macro: UART_TX_PARITY_EN adds a parity bit and the parity_odd input.
module uart_tx_framer #(
    parameter int unsigned NBITS         = 8,
    parameter int unsigned TICKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [NBITS-1:0] data_in,
    input  logic             tx_valid,
`ifdef UART_TX_PARITY_EN
    input  logic             parity_odd,
`endif
    output logic             tx_ready,
    output logic             Tx,
    output logic             busy,
    output logic             tx_done
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    localparam logic [3:0] TickLast = 4'(TICKS_PER_BIT - 1);
    localparam logic [3:0] DataLast = 4'(NBITS - 1);
    localparam logic [3:0] StopLast = 4'(STOP_BITS - 1);

    state_e           state_q, state_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [3:0]       tick_cnt_q, tick_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    logic             period_end;
    logic [NBITS-1:0] shift_next;

    // The tick seen on the accept edge is ignored because the FSM is still idle there.
    assign period_end = (state_q != StIdle) && tick && (tick_cnt_q == TickLast);
    assign shift_next = shift_q >> 1;

    // Next-state, counters and line value; Tx only moves on period ends or at accept.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        if (state_q != StIdle && tick) begin
            tick_cnt_d = period_end ? 4'd0 : tick_cnt_q + 4'd1;
        end

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (tx_valid && ready_q) begin
                    shift_d    = data_in;
                    state_d    = StStart;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    ready_d    = 1'b0;
                    tick_cnt_d = 4'd0;
                    bit_cnt_d  = 4'd0;
`ifdef UART_TX_PARITY_EN
                    parity_d   = (^data_in) ^ parity_odd;
`endif
                end
            end
            StStart: begin
                if (period_end) begin
                    state_d   = StData;
                    tx_d      = shift_q[0];
                    bit_cnt_d = 4'd0;
                end
            end
            StData: begin
                if (period_end) begin
                    shift_d   = shift_next;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == DataLast) begin
                        bit_cnt_d = 4'd0;
`ifdef UART_TX_PARITY_EN
                        state_d   = StParity;
                        tx_d      = parity_q;
`else
                        state_d   = StStop;
                        tx_d      = 1'b1;
`endif
                    end else begin
                        tx_d = shift_next[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (period_end) begin
                    state_d   = StStop;
                    tx_d      = 1'b1;
                    bit_cnt_d = 4'd0;
                end
            end
`endif
            StStop: begin
                tx_d = 1'b1;
                if (period_end) begin
                    if (bit_cnt_q == StopLast) begin
                        state_d   = StIdle;
                        busy_d    = 1'b0;
                        ready_d   = 1'b1;
                        done_d    = 1'b1;
                        bit_cnt_d = 4'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset aborts any frame and returns the line high at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            tick_cnt_q <= 4'd0;
            bit_cnt_q  <= 4'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign Tx       = tx_q;
    assign busy     = busy_q;
    assign tx_ready = ready_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: frame content and tick-exact bit timing, back-to-back
// frames, ignored requests while busy, mid-frame reset, two stop bits with a tick gap.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_framer;

    localparam int NB  = 8;
    localparam int TPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       reset, reset2;
    logic       tick1 = 1'b0, tick2 = 1'b0;
    logic       tick1_en = 1'b1, tick2_en = 1'b1;
    int         div = 0;
    logic [7:0] data1, data2;
    logic       valid1, valid2;
`ifdef UART_TX_PARITY_EN
    logic       podd1 = 1'b0, podd2 = 1'b0;
`endif
    logic       ready1, tx1, busy1, done1;
    logic       ready2, tx2, busy2, done2;

    int vectors = 0;
    int miscompares = 0;

    uart_tx_framer #(.NBITS(8), .TICKS_PER_BIT(16), .STOP_BITS(1)) dut (
        .clk(clk), .reset(reset), .tick(tick1), .data_in(data1), .tx_valid(valid1),
`ifdef UART_TX_PARITY_EN
        .parity_odd(podd1),
`endif
        .tx_ready(ready1), .Tx(tx1), .busy(busy1), .tx_done(done1)
    );

    uart_tx_framer #(.NBITS(8), .TICKS_PER_BIT(16), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset2), .tick(tick2), .data_in(data2), .tx_valid(valid2),
`ifdef UART_TX_PARITY_EN
        .parity_odd(podd2),
`endif
        .tx_ready(ready2), .Tx(tx2), .busy(busy2), .tx_done(done2)
    );

    initial forever #5 clk = ~clk;

    // Tick every 4 clks, driven on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            div   = (div + 1) % 4;
            tick1 = tick1_en && (div == 0);
            tick2 = tick2_en && (div == 0);
        end
    end

    // Expected line level for frame bit index b.
    function automatic logic exp_bit(input int b, input logic [7:0] d, input logic podd);
        if (b == 0) return 1'b0;
        if (b <= NB) return d[b-1];
        if (PAR != 0 && b == NB + 1) return (^d) ^ podd;
        return 1'b1;
    endfunction

    task automatic start_send(input int which, input logic [7:0] d, input bit align,
                              input bit hold);
        int guard;
        logic t_tx, t_busy, t_ready;
        guard = 0;
        if (align) begin
            // Land the accept edge on a tick edge.
            do begin
                @(posedge clk); #1;
                guard++;
            end while (div != 3 && guard < 10);
        end
        @(negedge clk);
        if (which == 0) begin data1 = d; valid1 = 1'b1; end
        else begin data2 = d; valid2 = 1'b1; end
        @(posedge clk); #1;
        t_tx    = which ? tx2 : tx1;
        t_busy  = which ? busy2 : busy1;
        t_ready = which ? ready2 : ready1;
        vectors++;
        if (t_tx !== 1'b0) begin
            miscompares++;
            $display("FAIL accept_tx dut%0d: got %b expected 0", which, t_tx);
        end
        vectors++;
        if (t_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_busy dut%0d: got %b expected 1", which, t_busy);
        end
        vectors++;
        if (t_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL accept_ready dut%0d: got %b expected 0", which, t_ready);
        end
        if (!hold) begin
            if (which == 0) valid1 = 1'b0;
            else valid2 = 1'b0;
        end
    endtask

    // Follows a frame from just after its accept edge, checking the line every clk.
    task automatic run_frame(input int which, input logic [7:0] d, input logic podd,
                             input int sb, input int gap_at, input int inject_at,
                             input int reset_at);
        int total, ticks, cyc, gap_left;
        bit gap_done;
        logic t_tick, t_tx, t_busy, t_ready, t_done, e_tx;
        total    = (1 + NB + PAR + sb) * TPB;
        ticks    = 0;
        cyc      = 0;
        gap_left = 0;
        gap_done = 1'b0;
        while (ticks < total && cyc < 8000) begin
            @(posedge clk); #1;
            cyc++;
            t_tick = which ? tick2 : tick1;
            if (t_tick) ticks++;
            if (gap_at >= 0 && !gap_done && ticks == gap_at) begin
                gap_done = 1'b1;
                gap_left = 100;
                if (which == 0) tick1_en = 1'b0; else tick2_en = 1'b0;
            end else if (gap_left > 0) begin
                gap_left--;
                if (gap_left == 0) begin
                    if (which == 0) tick1_en = 1'b1; else tick2_en = 1'b1;
                end
            end
            if (inject_at >= 0 && ticks == inject_at) begin
                data1  = 8'hFF;
                valid1 = 1'b1;
            end
            if (inject_at >= 0 && ticks == inject_at + 20) valid1 = 1'b0;
            if (reset_at >= 0 && ticks == reset_at) begin
                reset = 1'b1;
                #1;
                vectors++;
                if (tx1 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL reset_mid_tx: got %b expected 1", tx1);
                end
                vectors++;
                if (ready1 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL reset_mid_ready: got %b expected 1", ready1);
                end
                vectors++;
                if (busy1 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_mid_busy: got %b expected 0", busy1);
                end
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            t_tx    = which ? tx2 : tx1;
            t_busy  = which ? busy2 : busy1;
            t_ready = which ? ready2 : ready1;
            t_done  = which ? done2 : done1;
            e_tx    = exp_bit(ticks / TPB, d, podd);
            vectors++;
            if (t_tx !== e_tx) begin
                miscompares++;
                $display("FAIL line dut%0d data %h tick %0d: got %b expected %b",
                         which, d, ticks, t_tx, e_tx);
            end
            vectors++;
            if (t_busy !== (ticks < total)) begin
                miscompares++;
                $display("FAIL busy dut%0d tick %0d: got %b expected %b",
                         which, ticks, t_busy, ticks < total);
            end
            vectors++;
            if (t_ready !== (ticks >= total)) begin
                miscompares++;
                $display("FAIL ready dut%0d tick %0d: got %b expected %b",
                         which, ticks, t_ready, ticks >= total);
            end
            vectors++;
            if (t_done !== (ticks == total)) begin
                miscompares++;
                $display("FAIL done dut%0d tick %0d: got %b expected %b",
                         which, ticks, t_done, ticks == total);
            end
        end
        vectors++;
        if (ticks < total) begin
            miscompares++;
            $display("FAIL frame_timeout dut%0d: got %0d ticks expected %0d", which, ticks,
                     total);
        end
    endtask

    task automatic test_reset();
        vectors++;
        if (tx1 !== 1'b1) begin
            miscompares++; $display("FAIL reset_tx: got %b expected 1", tx1);
        end
        vectors++;
        if (ready1 !== 1'b1) begin
            miscompares++; $display("FAIL reset_ready: got %b expected 1", ready1);
        end
        vectors++;
        if (busy1 !== 1'b0) begin
            miscompares++; $display("FAIL reset_busy: got %b expected 0", busy1);
        end
        vectors++;
        if (done1 !== 1'b0) begin
            miscompares++; $display("FAIL reset_done: got %b expected 0", done1);
        end
        vectors++;
        if (tx2 !== 1'b1) begin
            miscompares++; $display("FAIL reset_tx2: got %b expected 1", tx2);
        end
    endtask

    task automatic test_basic();
        // Accept lands on a tick edge, so that tick must not count.
        start_send(0, 8'h55, 1'b1, 1'b0);
        run_frame(0, 8'h55, 1'b0, 1, -1, -1, -1);
    endtask

    task automatic test_back_to_back();
        start_send(0, 8'hA3, 1'b0, 1'b1);
        data1 = 8'h0F;
        run_frame(0, 8'hA3, 1'b0, 1, -1, -1, -1);
        @(posedge clk); #1;
        vectors++;
        if (tx1 !== 1'b0) begin
            miscompares++; $display("FAIL b2b_start: got %b expected 0", tx1);
        end
        vectors++;
        if (done1 !== 1'b0) begin
            miscompares++; $display("FAIL b2b_done: got %b expected 0", done1);
        end
        valid1 = 1'b0;
        run_frame(0, 8'h0F, 1'b0, 1, -1, -1, -1);
    endtask

    task automatic test_ignored();
        start_send(0, 8'h3C, 1'b0, 1'b0);
        run_frame(0, 8'h3C, 1'b0, 1, -1, 50, -1);
        repeat (200) begin
            @(posedge clk); #1;
            vectors++;
            if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
                miscompares++;
                $display("FAIL no_extra_frame: got tx %b busy %b expected tx 1 busy 0",
                         tx1, busy1);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        start_send(0, 8'h00, 1'b0, 1'b0);
        // Tick 72 falls in data bit 3.
        run_frame(0, 8'h00, 1'b0, 1, -1, -1, 72);
        start_send(0, 8'h81, 1'b0, 1'b0);
        run_frame(0, 8'h81, 1'b0, 1, -1, -1, -1);
    endtask

    task automatic test_stop2_gap();
        start_send(1, 8'h5A, 1'b0, 1'b0);
        run_frame(1, 8'h5A, 1'b0, 2, 40, -1, -1);
        start_send(1, 8'hC3, 1'b0, 1'b0);
        run_frame(1, 8'hC3, 1'b0, 2, (1 + NB + PAR) * TPB + 5, -1, -1);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        podd1 = 1'b0;
        start_send(0, 8'h07, 1'b0, 1'b0);
        run_frame(0, 8'h07, 1'b0, 1, -1, -1, -1);
        podd1 = 1'b1;
        start_send(0, 8'h07, 1'b0, 1'b0);
        run_frame(0, 8'h07, 1'b1, 1, -1, -1, -1);
    endtask
`endif

    initial begin
        reset  = 1'b1;
        reset2 = 1'b1;
        data1  = 8'h00;
        data2  = 8'h00;
        valid1 = 1'b0;
        valid2 = 1'b0;
        #2;
        test_reset();
        repeat (3) @(negedge clk);
        reset  = 1'b0;
        reset2 = 1'b0;
        test_basic();
        test_back_to_back();
        test_ignored();
        test_reset_mid_frame();
        test_stop2_gap();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
